// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

  // Arbitration mode encodings carried on the mode input
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Next channel index in a rotating search over n channels
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
interface rr_arb_mux_if
  import rr_arb_mux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  localparam int SW    = $clog2(N)
);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SW-1:0]      sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_sel;

  // View taken by the mux itself
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  // View taken by whatever drives the channels and consumes the output
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search: first requester after i_last_grant wins.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_last_grant,
  output logic [N-1:0]  o_grant,
  output logic [SW-1:0] o_idx
);

  int unsigned w_cand;
  logic        w_found;

  // Walk all N channels starting one past the last grant, wrapping at N-1
  always_comb begin
    // NOTE: blocking assignments with every output defaulted first keep this
    // loop purely combinational and free of inferred latches.
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = rr_next(int'(i_last_grant), N);
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[w_cand[SW-1:0]]) begin
        o_grant[w_cand[SW-1:0]] = 1'b1;
        o_idx                   = w_cand[SW-1:0];
        w_found                 = 1'b1;
      end
      w_cand = rr_next(w_cand, N);
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage.
// Mode 0 rotates priority after each accepted word; mode 1 takes only channel sel.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst,
  rr_arb_mux_if.slave bus
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SW-1:0]    r_out_sel;
  logic [SW-1:0]    r_last_grant;

  logic             w_load_en;
  logic [N-1:0]     w_rr_grant;
  logic [SW-1:0]    w_rr_idx;
  logic [N-1:0]     w_grant;
  logic [SW-1:0]    w_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arbiter (
    .i_req        (bus.in_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_rr_grant),
    .o_idx        (w_rr_idx)
  );

  // Pick the grant source; a sel outside 0..N-1 matches no channel and grants nothing
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    if (bus.mode == MODE_RR) begin
      w_grant = w_rr_grant;
      w_idx   = w_rr_idx;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.sel == SW'(i) && bus.in_valid[i]) begin
          w_grant[i] = 1'b1;
          w_idx      = SW'(i);
        end
      end
    end
  end

  // The output stage can take a word when empty or when its word leaves this cycle;
  // reset also blocks acceptance so nothing is consumed while the stage is cleared.
  assign w_load_en    = !r_out_valid || bus.out_ready;
  assign bus.in_ready = (w_load_en && !rst) ? w_grant : '0;
  assign w_xfer       = |bus.in_ready;

  // AND-OR select of the granted channel's word
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and priority pointer; the pointer moves only when a word is accepted
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_last_grant <= SW'(N - 1);
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_data;
      r_out_sel    <= w_idx;
      r_last_grant <= w_idx;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus a randomized
// run against a transaction-level model and an in-order scoreboard.
module tb_rr_arb_mux;
  import rr_arb_mux_pkg::*;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int SW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();

  rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who was last served, and what the output stage holds
  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_data;
  int          m_sel;

  typedef struct {
    logic [15:0] data;
    int          ch;
  } word_t;
  word_t sb[$];

  task automatic model_reset();
    m_ptr   = N - 1;
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
  endtask

  // Channel the rules say is accepted this cycle, or -1
  function automatic int ref_grant();
    if (m_valid && !bus.out_ready) return -1;
    if (bus.mode == MODE_RR) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (bus.in_valid[SW'(c)]) return c;
      end
      return -1;
    end
    if (bus.in_valid[bus.sel]) return int'(bus.sel);
    return -1;
  endfunction

  function automatic logic [N-1:0] ref_ready();
    int g;
    g = ref_grant();
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  // Advance the model by one clock using the current inputs, then step the DUT
  task automatic tick();
    int g;
    g = ref_grant();
    if (g >= 0) begin
      m_data  = bus.in_data[g*WIDTH +: WIDTH];
      m_sel   = g;
      m_valid = 1'b1;
      m_ptr   = g;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.mode     = MODE_RR;
    bus.sel      = '0;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    set_data(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); end
    checks++;
    if (bus.out_sel !== 2'd0) begin failures++; $display("FAIL reset_out_sel got=%0d exp=0", bus.out_sel); end
    checks++;
    if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", bus.in_ready); end
  endtask

  task automatic test_rr_all_valid();
    logic [15:0] exp_d [4];
    int          exp_ch;
    exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bus.mode      = MODE_RR;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    set_data(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int i = 0; i < 5; i++) begin
      exp_ch = i % N;
      #1;
      checks++;
      if (bus.in_ready !== (N'(1) << exp_ch)) begin
        failures++; $display("FAIL rr_in_ready cycle=%0d got=%b exp_ch=%0d", i, bus.in_ready, exp_ch);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== SW'(exp_ch) || bus.out_data !== exp_d[exp_ch]) begin
        failures++;
        $display("FAIL rr_output cycle=%0d got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                 i, bus.out_valid, bus.out_sel, bus.out_data, exp_ch, exp_d[exp_ch]);
      end
    end
  endtask

  task automatic test_stall();
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    #1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", bus.out_valid); end
    set_data(16'h0, 16'h0, 16'hABCD, 16'h0);
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin failures++; $display("FAIL stall_load_ready got=%b exp=0100", bus.in_ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hABCD || bus.out_sel !== 2'd2) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got v=%b data=%h sel=%0d exp v=1 data=abcd sel=2",
                 i, bus.out_valid, bus.out_data, bus.out_sel);
      end
      #1;
      checks++;
      if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready cycle=%0d got=%b exp=0000", i, bus.in_ready); end
      tick();
    end
    set_data(16'h0, 16'h0, 16'hBEEF, 16'h0);
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin failures++; $display("FAIL stall_release_ready got=%b exp=0100", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hBEEF) begin
      failures++; $display("FAIL stall_replace got v=%b data=%h exp v=1 data=beef", bus.out_valid, bus.out_data);
    end
    bus.in_valid = 4'b0000;
    #1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_fixed();
    bus.mode      = MODE_FIXED;
    bus.sel       = 2'd3;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_data(16'($urandom), 16'($urandom), 16'($urandom), 16'h3000 + 16'(i));
      #1;
      checks++;
      if (bus.in_ready !== 4'b1000) begin failures++; $display("FAIL fixed_ready cycle=%0d got=%b exp=1000", i, bus.in_ready); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3 || bus.out_data !== 16'h3000 + 16'(i)) begin
        failures++;
        $display("FAIL fixed_output cycle=%0d got v=%b sel=%0d data=%h exp v=1 sel=3 data=%h",
                 i, bus.out_valid, bus.out_sel, bus.out_data, 16'h3000 + 16'(i));
      end
    end
    bus.sel = 2'd1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0010) begin failures++; $display("FAIL fixed_sel_change got=%b exp=0010", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_sel !== 2'd1) begin failures++; $display("FAIL fixed_sel_out got=%0d exp=1", bus.out_sel); end
    bus.sel      = 2'd3;
    bus.in_valid = 4'b0111;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL fixed_invalid_ready got=%b exp=0000", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fixed_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    int exp_seq [3];
    exp_seq = '{1, 3, 1};
    bus.mode      = MODE_RR;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1000;
    set_data(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
    #1;
    tick();
    checks++;
    if (bus.out_sel !== 2'd3) begin failures++; $display("FAIL wrap_prime got=%0d exp=3", bus.out_sel); end
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== (N'(1) << exp_seq[i])) begin
        failures++; $display("FAIL wrap_ready step=%0d got=%b exp_ch=%0d", i, bus.in_ready, exp_seq[i]);
      end
      tick();
      checks++;
      if (bus.out_sel !== SW'(exp_seq[i])) begin
        failures++; $display("FAIL wrap_sel step=%0d got=%0d exp=%0d", i, bus.out_sel, exp_seq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.mode      = MODE_RR;
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    set_data(16'h1010, 16'h2020, 16'h5A5A, 16'h4040);
    #1;
    tick();
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    #1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h5A5A) begin
      failures++; $display("FAIL areset_setup got v=%b data=%h exp v=1 data=5a5a", bus.out_valid, bus.out_data);
    end
    bus.in_valid = 4'b1111;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_sel !== 2'd0) begin
      failures++;
      $display("FAIL areset_clear got v=%b data=%h sel=%0d exp v=0 data=0000 sel=0",
               bus.out_valid, bus.out_data, bus.out_sel);
    end
    checks++;
    if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL areset_ready got=%b exp=0000", bus.in_ready); end
    #1;
    rst = 1'b0;
    model_reset();
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL areset_first_ready got=%b exp=0001", bus.in_ready); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 16'h1010) begin
      failures++;
      $display("FAIL areset_first_word got v=%b sel=%0d data=%h exp v=1 sel=0 data=1010",
               bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_random();
    int    g;
    word_t w;
    sb.delete();
    if (m_valid) sb.push_back('{m_data, m_sel});
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus.in_valid  = 4'($urandom);
      bus.in_data   = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.sel       = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      #1;
      checks++;
      if (bus.out_valid !== m_valid) begin
        failures++; $display("FAIL rand_valid cycle=%0d got=%b exp=%b", cyc, bus.out_valid, m_valid);
      end
      checks++;
      if (bus.in_ready !== ref_ready()) begin
        failures++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", cyc, bus.in_ready, ref_ready());
      end
      if (m_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rand_underflow cycle=%0d got=emission exp=none", cyc);
        end else begin
          w = sb.pop_front();
          if (bus.out_data !== w.data || bus.out_sel !== SW'(w.ch)) begin
            failures++;
            $display("FAIL rand_word cycle=%0d got data=%h sel=%0d exp data=%h sel=%0d",
                     cyc, bus.out_data, bus.out_sel, w.data, w.ch);
          end
        end
      end
      g = ref_grant();
      if (g >= 0) sb.push_back('{bus.in_data[g*WIDTH +: WIDTH], g});
      tick();
    end
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    #1;
    if (m_valid && sb.size() != 0) begin
      w = sb.pop_front();
      checks++;
      if (bus.out_data !== w.data || bus.out_sel !== SW'(w.ch)) begin
        failures++;
        $display("FAIL rand_last_word got data=%h sel=%0d exp data=%h sel=%0d",
                 bus.out_data, bus.out_sel, w.data, w.ch);
      end
    end
    tick();
    checks++;
    if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL rand_drain got pending=%0d v=%b exp pending=0 v=0", sb.size(), bus.out_valid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rr_all_valid();
    test_stall();
    test_fixed();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
